// File: rtl/vga_pkg.sv
// Shared constants and owner encoding for the VGA frame-memory write path.
package vga_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int C_W      = 9;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [C_W-1:0] COLOR_BLACK = 9'h000;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_D1    = 2'd1,
    OWN_D2    = 2'd2,
    OWN_CLEAR = 2'd3
  } owner_e;

  // Fair pick between requesting drawers: prefer the one not served last.
  function automatic owner_e rr_pick(input logic last_d2, input logic r1, input logic r2);
    owner_e pick;
    if (r1 && r2) begin
      pick = last_d2 ? OWN_D1 : OWN_D2;
    end else if (r1) begin
      pick = OWN_D1;
    end else if (r2) begin
      pick = OWN_D2;
    end else begin
      pick = OWN_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/vga_owner_fsm.sv
// Owner state register with round-robin memory between drawers and clear priority.
module vga_owner_fsm
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   clr_act,
  input  logic   d1_req,
  input  logic   d2_req,
  output owner_e owner,
  output logic   d1_gnt,
  output logic   d2_gnt
);

  owner_e owner_q, owner_d;
  logic   last_d2_q, last_d2_d;
  logic   d1_gnt_q, d1_gnt_d;
  logic   d2_gnt_q, d2_gnt_d;

  always_comb begin
    owner_d   = OWN_IDLE;
    last_d2_d = last_d2_q;
    if (clr_act) begin
      owner_d = OWN_CLEAR;
    end else if (owner_q == OWN_D1 && d1_req) begin
      owner_d = OWN_D1;
    end else if (owner_q == OWN_D2 && d2_req) begin
      owner_d = OWN_D2;
    end else begin
      owner_d = rr_pick(last_d2_q, d1_req, d2_req);
    end

    // last_served only moves when a drawer session is (re)entered.
    if (owner_d == OWN_D1 && owner_q != OWN_D1) begin
      last_d2_d = 1'b0;
    end else if (owner_d == OWN_D2 && owner_q != OWN_D2) begin
      last_d2_d = 1'b1;
    end else begin
      last_d2_d = last_d2_q;
    end

    d1_gnt_d = (owner_d == OWN_D1);
    d2_gnt_d = (owner_d == OWN_D2);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q   <= OWN_IDLE;
      last_d2_q <= 1'b1;
      d1_gnt_q  <= 1'b0;
      d2_gnt_q  <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_d2_q <= last_d2_d;
      d1_gnt_q  <= d1_gnt_d;
      d2_gnt_q  <= d2_gnt_d;
    end
  end

  assign owner  = owner_q;
  assign d1_gnt = d1_gnt_q;
  assign d2_gnt = d2_gnt_q;

endmodule

// File: rtl/vga_write_mux.sv
// Arbitrated, registered write port into the VGA frame memory with reject counting.
module vga_write_mux
  import vga_pkg::*;
#(
  parameter int X_W   = vga_pkg::X_W,
  parameter int Y_W   = vga_pkg::Y_W,
  parameter int C_W   = vga_pkg::C_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_busy,
  input  logic [X_W-1:0]   clr_x,
  input  logic [Y_W-1:0]   clr_y,
  input  logic [C_W-1:0]   clr_color,
  input  logic             clr_write,
  input  logic             d1_req,
  output logic             d1_gnt,
  input  logic [X_W-1:0]   d1_x,
  input  logic [Y_W-1:0]   d1_y,
  input  logic [C_W-1:0]   d1_color,
  input  logic             d1_write,
  input  logic             d2_req,
  output logic             d2_gnt,
  input  logic [X_W-1:0]   d2_x,
  input  logic [Y_W-1:0]   d2_y,
  input  logic [C_W-1:0]   d2_color,
  input  logic             d2_write,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_color,
  output logic             vga_write,
  output logic [1:0]       owner,
  output logic [CNT_W-1:0] drop_cnt
);

  owner_e owner_s;
  logic   acc1_s, acc2_s, rej1_s, rej2_s;
  logic [1:0]       rej_s;
  logic [CNT_W:0]   sum_s;

  logic [X_W-1:0]   vga_x_q, vga_x_d;
  logic [Y_W-1:0]   vga_y_q, vga_y_d;
  logic [C_W-1:0]   vga_color_q, vga_color_d;
  logic             vga_write_q, vga_write_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  vga_owner_fsm u_owner_fsm (
    .clk     (clk),
    .resetn  (resetn),
    .clr_act (clr_busy | clr_write),
    .d1_req  (d1_req),
    .d2_req  (d2_req),
    .owner   (owner_s),
    .d1_gnt  (d1_gnt),
    .d2_gnt  (d2_gnt)
  );

  always_comb begin
    // A clear strobe beats any drawer, even one that currently owns the memory.
    acc1_s = !clr_write && (owner_s == OWN_D1) && d1_write;
    acc2_s = !clr_write && (owner_s == OWN_D2) && d2_write;
    rej1_s = d1_write && !acc1_s;
    rej2_s = d2_write && !acc2_s;
    rej_s  = {1'b0, rej1_s} + {1'b0, rej2_s};
    sum_s  = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, rej_s};
    drop_d = sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];

    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    vga_write_d = 1'b0;
    if (clr_write) begin
      vga_x_d     = clr_x;
      vga_y_d     = clr_y;
      vga_color_d = clr_color;
      vga_write_d = 1'b1;
    end else if (acc1_s) begin
      vga_x_d     = d1_x;
      vga_y_d     = d1_y;
      vga_color_d = d1_color;
      vga_write_d = 1'b1;
    end else if (acc2_s) begin
      vga_x_d     = d2_x;
      vga_y_d     = d2_y;
      vga_color_d = d2_color;
      vga_write_d = 1'b1;
    end else begin
      vga_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_x_q     <= {X_W{1'b0}};
      vga_y_q     <= {Y_W{1'b0}};
      vga_color_q <= {C_W{1'b0}};
      vga_write_q <= 1'b0;
      drop_q      <= {CNT_W{1'b0}};
    end else begin
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
      drop_q      <= drop_d;
    end
  end

  assign vga_x     = vga_x_q;
  assign vga_y     = vga_y_q;
  assign vga_color = vga_color_q;
  assign vga_write = vga_write_q;
  assign owner     = owner_s;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_vga_write_mux.sv
// Table-driven bench for vga_write_mux with a pixel scoreboard and reject model.
module tb_vga_write_mux;

  logic clk = 1'b0;
  logic resetn;
  logic clr_busy, clr_write, d1_req, d2_req, d1_write, d2_write;
  logic [9:0] clr_x, d1_x, d2_x, vga_x;
  logic [8:0] clr_y, d1_y, d2_y, vga_y;
  logic [8:0] clr_color, d1_color, d2_color, vga_color;
  logic d1_gnt, d2_gnt, vga_write;
  logic [1:0] owner;
  logic [15:0] drop_cnt;

  vga_write_mux dut (
    .clk(clk), .resetn(resetn),
    .clr_busy(clr_busy), .clr_x(clr_x), .clr_y(clr_y), .clr_color(clr_color), .clr_write(clr_write),
    .d1_req(d1_req), .d1_gnt(d1_gnt), .d1_x(d1_x), .d1_y(d1_y), .d1_color(d1_color), .d1_write(d1_write),
    .d2_req(d2_req), .d2_gnt(d2_gnt), .d2_x(d2_x), .d2_y(d2_y), .d2_color(d2_color), .d2_write(d2_write),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_write(vga_write),
    .owner(owner), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r1, r2, busy, cw, w1, w2;
    logic [1:0] exp_own;
    logic [1:0] acc;   // 0 none, 1 clear, 2 d1, 3 d2 accepted this cycle
  } row_t;

  row_t tbl[20];
  logic [27:0] sb_q[$];
  logic [27:0] last_px;
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  int k1 = 0;
  int k2 = 0;

  function automatic row_t mk(logic r1, logic r2, logic busy, logic cw, logic w1, logic w2,
                              logic [1:0] own, logic [1:0] acc);
    row_t r;
    r.r1 = r1; r.r2 = r2; r.busy = busy; r.cw = cw; r.w1 = w1; r.w2 = w2;
    r.exp_own = own; r.acc = acc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat_add(input int v, input int n);
    return (v + n > 65535) ? 65535 : v + n;
  endfunction

  task automatic drive(input row_t r);
    d1_req = r.r1; d2_req = r.r2; clr_busy = r.busy; clr_write = r.cw;
    d1_write = r.w1; d2_write = r.w2;
    clr_x = 10'd0; clr_y = 9'd0; clr_color = 9'h000;
    d1_x = 10'd10; d1_y = 9'(20 + k1); d1_color = 9'h1C0;
    d2_x = 10'(100 + k2); d2_y = 9'd200; d2_color = 9'h03F;
    case (r.acc)
      2'd1: sb_q.push_back({clr_x, clr_y, clr_color});
      2'd2: sb_q.push_back({d1_x, d1_y, d1_color});
      2'd3: sb_q.push_back({d2_x, d2_y, d2_color});
      default: ;
    endcase
    exp_drop = sat_add(exp_drop, int'(r.w1 && r.acc != 2'd2) + int'(r.w2 && r.acc != 2'd3));
    if (r.w1) k1++;
    if (r.w2) k2++;
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] own);
    logic [27:0] px;
    chk({tag, ".owner"}, 32'(owner), 32'(own));
    chk({tag, ".d1_gnt"}, 32'(d1_gnt), 32'(own == 2'd1));
    chk({tag, ".d2_gnt"}, 32'(d2_gnt), 32'(own == 2'd2));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    if (sb_q.size() > 0) begin
      px = sb_q.pop_front();
      chk({tag, ".vga_write"}, 32'(vga_write), 32'd1);
      chk({tag, ".vga_pixel"}, 32'({vga_x, vga_y, vga_color}), 32'(px));
      last_px = px;
    end else begin
      chk({tag, ".vga_write"}, 32'(vga_write), 32'd0);
      chk({tag, ".vga_hold"}, 32'({vga_x, vga_y, vga_color}), 32'(last_px));
    end
  endtask

  initial begin
    tbl[0]  = mk(1,1,0,0,0,0, 2'd1, 2'd0);  // simultaneous: D1 first
    tbl[1]  = mk(1,1,0,0,1,0, 2'd1, 2'd2);
    tbl[2]  = mk(1,1,0,0,1,0, 2'd1, 2'd2);
    tbl[3]  = mk(1,1,0,0,1,0, 2'd1, 2'd2);
    tbl[4]  = mk(1,1,0,0,1,0, 2'd1, 2'd2);
    tbl[5]  = mk(0,1,0,0,0,0, 2'd2, 2'd0);  // D1 release: D2 with no gap
    tbl[6]  = mk(1,1,0,0,0,0, 2'd2, 2'd0);  // D1 waits for D2 release
    tbl[7]  = mk(1,1,0,0,0,1, 2'd2, 2'd3);
    tbl[8]  = mk(1,0,0,0,0,0, 2'd1, 2'd0);
    tbl[9]  = mk(0,1,0,0,0,0, 2'd2, 2'd0);
    tbl[10] = mk(0,1,1,0,0,1, 2'd3, 2'd3);  // preempt: write this cycle still lands
    tbl[11] = mk(0,1,1,1,0,1, 2'd3, 2'd1);  // clear pixel beats d2_write
    tbl[12] = mk(0,1,0,0,0,0, 2'd2, 2'd0);  // D2 resumes
    tbl[13] = mk(0,0,0,0,1,0, 2'd0, 2'd0);  // ungranted d1 writes
    tbl[14] = mk(0,0,0,0,1,0, 2'd0, 2'd0);
    tbl[15] = mk(0,0,0,0,1,0, 2'd0, 2'd0);
    tbl[16] = mk(1,0,0,0,1,0, 2'd1, 2'd0);  // write in grant-issue cycle rejected
    tbl[17] = mk(1,0,0,1,1,0, 2'd3, 2'd1);  // clr_write wins over owning D1
    tbl[18] = mk(1,0,0,0,0,0, 2'd1, 2'd0);
    tbl[19] = mk(0,0,0,0,0,0, 2'd0, 2'd0);

    last_px = 28'd0;
    resetn = 1'b0;
    drive(mk(0,0,0,0,0,0, 2'd0, 2'd0));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_outputs("reset", 2'd0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_outputs($sformatf("row%0d", i), tbl[i].exp_own);
      if (i == 15) chk("drop_after_rejects", 32'(drop_cnt), 32'd4);
    end

    // Saturation: two rejects per cycle until the counter pins at all-ones.
    drive(mk(0,0,0,0,1,1, 2'd0, 2'd0));
    for (int n = 1; n <= 32770; n++) begin
      @(negedge clk);
      if (n > 1) exp_drop = sat_add(exp_drop, 2);
      if (n == 1000) chk("drop_mid", 32'(drop_cnt), 32'(exp_drop));
    end
    chk("drop_sat", 32'(drop_cnt), 32'hFFFF);
    drive(mk(0,0,0,0,0,0, 2'd0, 2'd0));
    @(negedge clk);
    chk("drop_sat_hold", 32'(drop_cnt), 32'hFFFF);

    // Reset during a clear.
    drive(mk(0,0,1,1,0,0, 2'd3, 2'd1));
    @(negedge clk);
    check_outputs("clear", 2'd3);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid.vga_write", 32'(vga_write), 32'd0);
    chk("rst_mid.owner", 32'(owner), 32'd0);
    chk("rst_mid.gnt", 32'({d1_gnt, d2_gnt}), 32'd0);
    chk("rst_mid.drop_cnt", 32'(drop_cnt), 32'd0);
    resetn = 1'b1;
    drive(mk(0,0,0,0,0,0, 2'd0, 2'd0));
    @(negedge clk);
    chk("post_rst.owner", 32'(owner), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_write_mux.md
# vga_write_mux

Single-port arbiter and output register between the pixel writers and the 640x480, 9-bit-colour VGA frame memory. The screen-clear engine has absolute priority and no handshake. Two drawer ports (bricks/HUD, paddle/ball) share the memory via req/gnt sessions with round-robin fairness. All outputs are registered and form the only write path into the VGA adapter.

## Interface
- X_W, default 10: x coordinate width (0..639)
- Y_W, default 9: y coordinate width (0..479)
- C_W, default 9: colour width (RGB 3:3:3)
- CNT_W, default 16: drop counter width
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- clr_busy  in  1  clear engine active
- clr_x / clr_y / clr_color  in  X_W / Y_W / C_W  clear pixel
- clr_write  in  1  clear pixel strobe
- d1_req, d2_req  in  1 each  drawer session request, held for the whole session
- d1_gnt, d2_gnt  out  1 each  registered grant
- dN_x / dN_y / dN_color  in  X_W / Y_W / C_W  drawer pixel
- dN_write  in  1  drawer pixel strobe
- vga_x / vga_y / vga_color  out  X_W / Y_W / C_W  memory write address and data
- vga_write  out  1  memory write enable
- owner  out  2  current owner: 0 IDLE, 1 D1, 2 D2, 3 CLEAR
- drop_cnt  out  CNT_W  saturating count of rejected drawer writes

## Operation
- Owner FSM states: IDLE, D1, D2, CLEAR. The register updates every edge.
- clr_act = clr_busy | clr_write.
- Next owner, by priority:
  - clr_act: CLEAR, from any state.
  - Current owner is Dk and dk_req is high: stay in Dk.
  - One or more drawers requesting: pick the drawer other than last_served if it requests, otherwise the requesting one.
  - Otherwise: IDLE.
- last_served updates whenever a drawer state is entered.
- Preemption: a clear request takes the memory from an active drawer. The drawer sees gnt fall and must hold its pixel. The session resumes when grant returns, with dk_req still high.
- dk_gnt = (owner == Dk), registered, so it changes on the same edge as owner.
- Datapath select, evaluated each cycle:
  - If clr_write: forward the clear pixel. This applies regardless of owner.
  - Else if owner is Dk and dk_write: forward the Dk pixel.
  - Else: vga_write <= 0 and address/colour hold their previous values.
- Drawer write rejection: any dk_write not accepted is a reject, either because dk_gnt is low or because clr_write wins the same cycle. drop_cnt increments by the number of rejects that cycle (0..2) and saturates at all-ones.

## Timing
- Reset: owner=IDLE, d1_gnt=d2_gnt=0, vga_x=vga_y=vga_color=0, vga_write=0, drop_cnt=0, last_served=D2 (so D1 wins the first tie).
- Reset mid-session aborts everything immediately. In-flight pixels are discarded.
- Datapath latency: accepted input in cycle t appears on vga_* in cycle t+1, one vga_write pulse per accepted pixel. Full throughput is one pixel per clock.
- Grant latency: dk_req rising in cycle t gives dk_gnt high in t+1 when the memory is free.
- Release: dk_req falling in cycle t gives dk_gnt low in t+1. A pending requester is granted in t+1 with no idle cycle.
- Clear preemption: clr_busy rising in cycle t gives owner=CLEAR and all gnt low in t+1. A drawer write in cycle t is still accepted.
- Clear exit: owner leaves CLEAR in the cycle after both clr_busy and clr_write are low.
- Simultaneous requests from IDLE: D1 first, then D2 on D1 release. Requests alternate thereafter.
- If dk_req and dk_write are asserted in the same cycle as grant issue, that write is rejected because the grant is not yet visible.

## Structure
- Shared package vga_pkg holds:
  - X_W, Y_W, C_W, SCREEN_W=640, SCREEN_H=480
  - COLOR_BLACK
  - owner encoding typedef (IDLE/D1/D2/CLEAR)
- Sub-module vga_owner_fsm contains the owner register, last_served, and the gnt outputs.
- The mux, output register and drop counter stay in vga_write_mux.

## Test plan
- Reset: after resetn low then high, all outputs are 0 and owner=0. Assert d1_req, d2_req together: d1_gnt=1 next cycle, d2_gnt=0.
- Drawer stream: with D1 granted, 4 writes at (10,20..23), colour 9'h1C0. vga_write pulses 4 cycles, each one cycle after input, with matching coordinates.
- Round-robin: D1 releases while d2_req is held high. d2_gnt=1 on the following edge with no gap. Re-raise d1_req: D1 is granted only after D2 releases.
- Preemption: clr_busy rises mid-D2 session. d2_gnt=0 and owner=3 next cycle. The clear pixel (0,0) black appears. D2 is re-granted one cycle after clr_busy and clr_write both go low.
- Rejects: d1_write without grant for 3 cycles, plus one same-cycle clash of clr_write and d2_write. drop_cnt=4. Force 65535 rejects: drop_cnt saturates at 16'hFFFF.
- Reset mid-clear: resetn low during CLEAR gives vga_write=0, owner=0, all gnt 0 on the next edge.
